// File: rtl/rc6_decrypt.sv
// RC6-32/ROUNDS/16 iterative decryption core.
// One round per clock; round keys are read live from the expanded-key bus.
module rc6_decrypt #(
  parameter int unsigned ROUNDS = 20
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [32*(2*ROUNDS+4)-1:0]     i_exkey,
  input  logic                           i_key_ok,
  input  logic [127:0]                   i_din,
  input  logic                           i_din_en,
  output logic                           o_ready,
  output logic [127:0]                   o_dout,
  output logic                           o_dout_en,
  output logic                           o_busy
);

  localparam int unsigned NK = 2*ROUNDS + 4;
  localparam int unsigned CW = $clog2(ROUNDS + 1);
  localparam int unsigned IW = $clog2(NK);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic [31:0]     a_q, b_q, c_q, d_q;
  logic [31:0]     s [NK];
  logic [IW-1:0]   idx_e, idx_o;
  logic [31:0]     na, nb, nc, nd, u, t, a_rnd, c_rnd, b_fin, d_fin;
  logic [31:0]     in_a, in_b, in_c, in_d;
  logic            accept, last;

  function automatic logic [31:0] swap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [31:0] rol32(input logic [31:0] x, input logic [4:0] n);
    return (x << n) | (x >> (6'd32 - {1'b0, n}));
  endfunction

  function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] n);
    return (x >> n) | (x << (6'd32 - {1'b0, n}));
  endfunction

  // f(x) = rol(x*(2x+1), 5); 2x+1 mod 2^32 is just x shifted with a 1 in the LSB
  function automatic logic [31:0] f_mix(input logic [31:0] x);
    logic [31:0] p;
    p = x * {x[30:0], 1'b1};
    return rol32(p, 5'd5);
  endfunction

  // Unpack the round-key bus, S[0] in the most significant word
  always_comb begin
    for (int unsigned k = 0; k < NK; k++) begin
      s[k] = i_exkey[32*(NK-k)-1 -: 32];
    end
  end

  // One inverse round plus post-whitening for the final round
  always_comb begin
    idx_e = IW'({cnt, 1'b0});
    idx_o = IW'({cnt, 1'b1});
    na    = d_q;
    nb    = a_q;
    nc    = b_q;
    nd    = c_q;
    u     = f_mix(nd);
    t     = f_mix(nb);
    c_rnd = ror32(nc - s[idx_o], t[4:0]) ^ u;
    a_rnd = ror32(na - s[idx_e], u[4:0]) ^ t;
    b_fin = nb - s[0];
    d_fin = nd - s[1];
    last  = (cnt == CW'(1));
    in_a  = swap32(i_din[127:96]);
    in_b  = swap32(i_din[95:64]);
    in_c  = swap32(i_din[63:32]);
    in_d  = swap32(i_din[31:0]);
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state and status outputs; acceptance is also held off during the
  // completion-strobe cycle so a block offered then is dropped, not queued
  always_comb begin
    state_nx = state;
    o_ready  = 1'b0;
    o_busy   = 1'b0;
    accept   = 1'b0;
    if (state == IDLE) begin
      o_ready = i_key_ok && !o_dout_en && !i_rst;
      accept  = i_din_en && i_key_ok && !o_dout_en;
      if (accept) state_nx = RUN;
    end else begin
      o_busy = 1'b1;
      if (!i_key_ok || last) state_nx = IDLE;
    end
  end

  // Datapath: pre-whitening on accept, one round per edge, result capture
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      d_q       <= '0;
      cnt       <= '0;
      o_dout    <= '0;
      o_dout_en <= 1'b0;
    end else begin
      o_dout_en <= 1'b0;
      if (state == IDLE) begin
        if (accept) begin
          a_q <= in_a - s[NK-2];
          b_q <= in_b;
          c_q <= in_c - s[NK-1];
          d_q <= in_d;
          cnt <= CW'(ROUNDS);
        end
      end else if (!i_key_ok) begin
        cnt <= '0;
      end else begin
        a_q <= a_rnd;
        c_q <= c_rnd;
        cnt <= cnt - CW'(1);
        if (last) begin
          b_q       <= b_fin;
          d_q       <= d_fin;
          o_dout    <= {swap32(a_rnd), swap32(b_fin), swap32(c_rnd), swap32(d_fin)};
          o_dout_en <= 1'b1;
        end else begin
          b_q <= nb;
          d_q <= nd;
        end
      end
    end
  end

endmodule
